// File: rtl/filt_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : filt_sample_sequencer
// Brief   : Buffers XADC samples, issues them to the filters over start/done,
//           and streams captured results out on valid/ready.
// Revision: 1.0 - initial release
// ============================================================================
module filt_sample_sequencer #(
    parameter int XADC_DATA_SIZE = 16,
    parameter int FIFO_AW        = 4,
    parameter int START_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_W           = 13
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [1:0]                sel_in,
    input  logic [XADC_DATA_SIZE-1:0] adc_data,
    input  logic                      adc_valid,
    output logic                      filt_start,
    output logic [1:0]                filt_select,
    output logic [XADC_DATA_SIZE-1:0] filt_input,
    input  logic [XADC_DATA_SIZE-1:0] filt_result,
    input  logic                      filt_done,
    output logic [XADC_DATA_SIZE-1:0] res_data,
    output logic [1:0]                res_sel,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [FIFO_AW:0]          fifo_level,
    output logic                      overflow,
    output logic                      timeout,
    input  logic                      clear_flags,
    output logic                      busy
);

    localparam logic [FIFO_AW:0] c_DEPTH      = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0] c_LEVEL_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [TO_W-1:0]  c_CNT_ONE    = TO_W'(1);
    localparam logic [TO_W-1:0]  c_START_LAST = TO_W'(START_CYCLES - 1);
    localparam logic [TO_W-1:0]  c_TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t                    r_state;
    logic [XADC_DATA_SIZE-1:0] r_mem [0:(1<<FIFO_AW)-1];
    logic [FIFO_AW-1:0]        r_wr_ptr;
    logic [FIFO_AW-1:0]        r_rd_ptr;
    logic [FIFO_AW:0]          r_level;
    logic                      r_done_d;
    logic [TO_W-1:0]           r_cnt;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_done_rise;

    assign w_empty     = (r_level == '0);
    assign w_full      = (r_level == c_DEPTH);
    assign w_pop       = (r_state == S_IDLE) && enable && !w_empty;
    // A full FIFO still takes a sample when the head leaves in the same cycle.
    assign w_push      = adc_valid && (!w_full || w_pop);
    assign w_done_rise = filt_done && !r_done_d;

    assign fifo_level  = r_level;
    assign busy        = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= adc_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LEVEL_ONE;
                2'b01:   r_level <= r_level - c_LEVEL_ONE;
                default: r_level <= r_level;
            endcase
            if (adc_valid && !w_push) begin
                overflow <= 1'b1;
            end else if (clear_flags) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_done_d    <= 1'b0;
            r_cnt       <= '0;
            filt_start  <= 1'b0;
            filt_select <= 2'b00;
            filt_input  <= '0;
            res_data    <= '0;
            res_sel     <= 2'b00;
            res_valid   <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            r_done_d <= filt_done;
            if (clear_flags) begin
                timeout <= 1'b0;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        filt_input  <= r_mem[r_rd_ptr];
                        filt_select <= (sel_in == 2'b11) ? 2'b00 : sel_in;
                        filt_start  <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= S_START;
                    end
                end
                S_START: begin
                    if (r_cnt == c_START_LAST) begin
                        filt_start <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= S_WAIT;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                S_WAIT: begin
                    if (w_done_rise) begin
                        res_data  <= filt_result;
                        res_sel   <= filt_select;
                        res_valid <= 1'b1;
                        r_state   <= S_OUT;
                    end else if (r_cnt == c_TO_LAST) begin
                        // Placed after the clear so a same-cycle timeout wins.
                        timeout <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                S_OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
